// File: rtl/exec_alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, muldiv FSM states and result flags.
package exec_alu_pkg;

    localparam logic [4:0] OP_AND    = 5'h00;
    localparam logic [4:0] OP_OR     = 5'h01;
    localparam logic [4:0] OP_ADD    = 5'h02;
    localparam logic [4:0] OP_XOR    = 5'h03;
    localparam logic [4:0] OP_SLL    = 5'h04;
    localparam logic [4:0] OP_SRL    = 5'h05;
    localparam logic [4:0] OP_SUB    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_SLT    = 5'h08;
    localparam logic [4:0] OP_SLTU   = 5'h09;
    localparam logic [4:0] OP_PASSB  = 5'h0A;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/exec_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one accumulator,
// one bit per CALC cycle; the first CALC cycle takes operand magnitudes.
module exec_alu_muldiv
    import exec_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       cnt;
    logic [4:0]          op_q;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic [XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]   acc;
    logic                neg_q;
    logic                neg_r;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = CALC;
                CALC:    if (cnt == LAST) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        sign_a   = (op_q == OP_MULH || op_q == OP_MULHSU || op_q == OP_DIV || op_q == OP_REM) && opa[XLEN-1];
        sign_b   = (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM) && opb[XLEN-1];
        mag_a    = sign_a ? -opa : opa;
        mag_b    = sign_b ? -opb : opb;
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, mcand};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res = quo;
            default:                       res = rem;
        endcase
    end

    // Divide keeps {remainder, quotient} in acc; multiply keeps {partial product, multiplier}.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            op_q  <= '0;
            opa   <= '0;
            opb   <= '0;
            mcand <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    opa  <= a;
                    opb  <= b;
                    cnt  <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        if (op_q[2]) begin
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            mcand <= mag_b;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, mag_b};
                            mcand <= mag_a;
                        end
                    end else if (op_q[2]) begin
                        if (!div_diff[XLEN]) acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else                 acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle integer ops registered at acceptance, with
// multiply/divide delegated to the iterative engine; valid/ready on both sides.
module exec_alu
    import exec_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow,
    output logic            busy
);

    logic            accept;
    logic            start;
    logic            div_zero;
    logic            div_ovf;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_res;
    logic [XLEN-1:0] alu_res;
    logic            alu_carry;
    logic            alu_ovf;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;
    logic [SHW-1:0]  shamt;
    flags_t          flags_q;

    assign in_ready = reset_n && !md_busy && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign div_zero = (b == '0);
    assign div_ovf  = (op == OP_DIV || op == OP_REM) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // Divide corner cases resolve here in one cycle and never start the engine.
    assign start    = accept && is_muldiv(op) && !(is_div(op) && (div_zero || div_ovf));

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shamt     = b[SHW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_ADD: begin
                alu_res   = sum[XLEN-1:0];
                alu_carry = sum[XLEN];
                alu_ovf   = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res   = diff[XLEN-1:0];
                alu_carry = diff[XLEN];
                alu_ovf   = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_PASSB: alu_res = b;
            OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : a;
            OP_REM, OP_REMU: alu_res = div_zero ? a : '0;
            default:  alu_res = '0;
        endcase
    end

    exec_alu_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (md_busy),
        .done    (md_done),
        .res     (md_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !start) begin
            out_valid        <= 1'b1;
            result           <= alu_res;
            flags_q.zero     <= (alu_res == '0);
            flags_q.negative <= alu_res[XLEN-1];
            flags_q.carry    <= alu_carry;
            flags_q.overflow <= alu_ovf;
        end else if (md_done) begin
            out_valid        <= 1'b1;
            result           <= md_res;
            flags_q.zero     <= (md_res == '0);
            flags_q.negative <= md_res[XLEN-1];
            flags_q.carry    <= 1'b0;
            flags_q.overflow <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign carry    = flags_q.carry;
    assign overflow = flags_q.overflow;
    assign busy     = md_busy;

endmodule

// File: tb/tb_exec_alu.sv
// Directed vector bench for exec_alu: table of single/multi-cycle ops plus
// hand-written backpressure, flush and mid-operation reset sequences.
module tb_exec_alu;
    import exec_alu_pkg::*;

    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 2;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        busy;

    int   checks = 0;
    int   fails  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    exec_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vr, input logic [3:0] vf, input int vl);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.res = vr; v.flags = vf; v.lat = vl;
        vecs.push_back(v);
    endtask

    // Issue one op with out_ready high, measure edges to out_valid, then check it drains.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int lat;
        int leaks;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        check_output($sformatf("v%0d in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat   = 0;
        leaks = 0;
        while (!out_valid && lat < MD_LAT + 10) begin
            if (in_ready || !busy) leaks++;
            @(posedge clk); #1;
            lat++;
        end
        check_output($sformatf("v%0d latency", idx), lat, v.lat);
        check_output($sformatf("v%0d result", idx), result, v.res);
        check_output($sformatf("v%0d flags", idx), {zero, negative, carry, overflow}, v.flags);
        check_output($sformatf("v%0d busy_hold", idx), leaks, 0);
        @(posedge clk); #1;
        check_output($sformatf("v%0d drop", idx), out_valid, 0);
    endtask

    task automatic start_divu_and_wait(input int edges);
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic watch_no_result(input string name);
        int seen;
        seen = 0;
        repeat (MD_LAT + 5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output(name, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // flags column is {zero, negative, carry, overflow}
        add_vec(OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 0);
        add_vec(OP_SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 0);
        add_vec(OP_SUB,    32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0110, 0);
        add_vec(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 0);
        add_vec(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 0);
        add_vec(OP_OR,     32'h12340000, 32'h00005678, 32'h12345678, 4'b0000, 0);
        add_vec(OP_XOR,    32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000, 0);
        add_vec(OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 0);
        add_vec(OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 0);
        add_vec(OP_SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100, 0);
        add_vec(OP_SRA,    32'h7FFFFFF0, 32'h00000024, 32'h07FFFFFF, 4'b0000, 0);
        add_vec(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 0);
        add_vec(OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 0);
        add_vec(OP_PASSB,  32'h00000005, 32'hABCD0000, 32'hABCD0000, 4'b0100, 0);
        add_vec(5'h0B,     32'h00000005, 32'h00000006, 32'h00000000, 4'b1000, 0);
        add_vec(5'h1F,     32'h00000005, 32'h00000006, 32'h00000000, 4'b1000, 0);
        add_vec(OP_MUL,    32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 4'b0100, MD_LAT);
        add_vec(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, MD_LAT);
        add_vec(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, MD_LAT);
        add_vec(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b0100, MD_LAT);
        add_vec(OP_MUL,    32'h00000000, 32'h00012345, 32'h00000000, 4'b1000, MD_LAT);
        add_vec(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100, MD_LAT);
        add_vec(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100, MD_LAT);
        add_vec(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 4'b0000, MD_LAT);
        add_vec(OP_DIVU,   32'd100,      32'd7,        32'd14,       4'b0000, MD_LAT);
        add_vec(OP_REMU,   32'd100,      32'd7,        32'd2,        4'b0000, MD_LAT);
        add_vec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 0);
        add_vec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 0);
        add_vec(OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 0);
        add_vec(OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 4'b0000, 0);
        add_vec(OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 0);
        add_vec(OP_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 4'b0100, 0);

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        op = OP_ADD; a = 32'h1; b = 32'h1;
        repeat (3) @(negedge clk);
        check_output("reset in_ready", in_ready, 0);
        check_output("reset out_valid", out_valid, 0);
        check_output("reset result", result, 0);
        check_output("reset flags", {zero, negative, carry, overflow}, 4'b0000);
        check_output("reset busy", busy, 0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        check_output("release in_ready", in_ready, 1);

        foreach (vecs[i]) apply_stimulus(vecs[i], i);

        $display("[TB] backpressure sequence");
        @(negedge clk);
        out_ready = 1'b0; op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        check_output("b2b add valid", out_valid, 1);
        check_output("b2b add result", result, 32'd3);
        op = OP_XOR; a = 32'hF; b = 32'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output($sformatf("b2b stall%0d in_ready", i), in_ready, 0);
            @(negedge clk);
            check_output($sformatf("b2b stall%0d result", i), result, 32'd3);
            check_output($sformatf("b2b stall%0d valid", i), out_valid, 1);
            check_output($sformatf("b2b stall%0d flags", i), {zero, negative, carry, overflow}, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check_output("b2b release in_ready", in_ready, 1);
        @(negedge clk);
        check_output("b2b xor result", result, 32'hC);
        check_output("b2b xor valid", out_valid, 1);
        op = OP_SLT; a = 32'hFFFFFFFF; b = 32'h0;
        @(negedge clk);
        check_output("b2b slt result", result, 32'h1);
        check_output("b2b slt valid", out_valid, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check_output("b2b drain", out_valid, 0);

        $display("[TB] flush sequence");
        start_divu_and_wait(10);
        check_output("flush pre busy", busy, 1);
        flush = 1'b1;
        #1;
        check_output("flush in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_output("flush busy", busy, 0);
        check_output("flush out_valid", out_valid, 0);
        check_output("flush in_ready after", in_ready, 1);
        watch_no_result("flush no result");

        $display("[TB] mid-operation reset sequence");
        start_divu_and_wait(10);
        check_output("rst pre busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_output("rst in_ready", in_ready, 0);
        check_output("rst busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("rst in_ready after", in_ready, 1);
        watch_no_result("rst no result");

        apply_stimulus(vecs[24], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/exec_alu.md
EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 Parameter XLEN, default 32; datapath width, SHALL be one of 32 or 64.
REQ-002 Parameter SHW, default $clog2(XLEN); shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort of in-flight and held work.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  unit accepts request this cycle.
REQ-008 op  input  5  operation code; encodings in REQ-013.
REQ-009 a, b  input  XLEN  operands.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  XLEN; zero, negative, carry, overflow  output  1 each; busy  output  1 (multi-cycle op in progress).

Function
REQ-013 Op codes: 00 AND, 01 OR, 02 ADD, 03 XOR, 04 SLL, 05 SRL, 06 SUB, 07 SRA, 08 SLT, 09 SLTU, 0A PASSB (LUI); 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; all others undefined -> result 0.
REQ-014 Handshake: transfer when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-015 Single-cycle ops (00-0A, undefined): result registered; out_valid rises on the edge following acceptance; throughput 1 per cycle under continuous out_ready.
REQ-016 Output held stable (result, flags, out_valid) while out_valid && !out_ready; out_valid drops on the edge where out_ready is sampled high and no new result is produced.
REQ-017 FSM states IDLE, CALC, DONE: IDLE -> CALC on accepted MUL/DIV op; CALC counts XLEN iterations, then -> DONE; DONE loads output registers, -> IDLE.
REQ-018 MUL/DIV latency: out_valid rises exactly XLEN+2 edges after the acceptance edge (34 for XLEN=32); busy high in CALC and DONE.
REQ-019 Multiply: iterative shift-add on |a|,|b| per signedness, 2*XLEN product; MUL returns low half, MULH/MULHSU/MULHU high half, signs per RISC-V M.
REQ-020 Divide: restoring, one quotient bit per cycle, signs fixed up at DONE; REM sign follows dividend.
REQ-021 Divide-by-zero: DIV/DIVU quotient all ones, REM/REMU = a; completes in 1 cycle (no CALC).
REQ-022 Signed overflow (a = most-negative, b = -1): DIV = a, REM = 0; completes in 1 cycle.
REQ-023 Flags from registered result: zero = (result==0); negative = result[XLEN-1].
REQ-024 carry: ADD = carry-out of bit XLEN-1; SUB = borrow (1 when a < b unsigned); 0 for all other ops.
REQ-025 overflow: ADD = operands same sign, result sign differs; SUB = operands differ in sign, result sign differs from a; 0 otherwise (including DIV overflow case).
REQ-026 Shifts use b[SHW-1:0] only; SRA replicates a[XLEN-1].
REQ-027 flush: next edge state -> IDLE, out_valid -> 0, iteration counter -> 0; in_ready low during flush cycle; flushed result never appears.
REQ-028 Simultaneous out_ready and new single-cycle acceptance: new result replaces old in same edge, out_valid stays 1.

Reset
REQ-029 On reset_n low: state IDLE, out_valid 0, result 0, all flags 0, busy 0, counter 0, operand/accumulator registers 0.
REQ-030 Reset asserted mid-CALC aborts operation; no result is produced after release.
REQ-031 in_ready SHALL be 0 while reset_n low and 1 on first edge after release.

Structure
REQ-032 Package exec_alu_pkg: op code constants, FSM state enum, flag struct.
REQ-033 Sub-module exec_alu_muldiv holds iterative multiply/divide engine, counter and FSM; single-cycle ALU datapath stays in exec_alu.

Verification
REQ-034 ADD a=FFFFFFFF, b=1 -> result 0, zero=1, carry=1, overflow=0, out_valid next cycle.
REQ-035 SUB a=80000000, b=1 -> result 7FFFFFFF, overflow=1, carry=0, negative=0.
REQ-036 MULH a=80000000, b=80000000 -> result 40000000, out_valid 34 edges after acceptance, in_ready low until completion.
REQ-037 DIV a=80000000, b=FFFFFFFF -> 80000000 in 1 cycle; DIVU a=7, b=0 -> FFFFFFFF; REM a=-7, b=2 -> FFFFFFFF.
REQ-038 Back-to-back ADD/XOR/SLT with out_ready held 0 for 3 cycles -> first result held stable, in_ready 0, no loss, order preserved.
REQ-039 DIVU accepted, flush asserted at iteration 10 -> no out_valid, in_ready 1 next cycle; repeat with reset_n pulse -> same.
